// File: rtl/uart_pkg.sv
// Shared serial-receiver definitions: FSM states, frame geometry and the
// frame-length clamp applied when the first start bit is seen.
package uart_pkg;

    localparam int MAX_BYTES = 3;
    localparam int BYTE_W    = 8;
    localparam int DATA_W    = 24;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // 0 means a single byte; anything above the frame capacity saturates.
    function automatic logic [1:0] clamp_len(input logic [2:0] n);
        if (n == 3'd0) begin
            return 2'd1;
        end else if (n[2]) begin
            return 2'd3;
        end else begin
            return n[1:0];
        end
    endfunction

endpackage

// File: rtl/rx_multi_byte_if.sv
// Serial line, frame length and frame-result signals of rx_multi_byte.
// The line driver takes the master side; the receiver takes the slave side.
interface rx_multi_byte_if;
    import uart_pkg::*;

    logic              bit_in;
    logic [2:0]        bytes_to_receive;
    logic [DATA_W-1:0] data_received;
    logic              received;
    logic              receiving;
    logic              framing_error;

    modport master (
        output bit_in,
        output bytes_to_receive,
        input  data_received,
        input  received,
        input  receiving,
        input  framing_error
    );

    modport slave (
        input  bit_in,
        input  bytes_to_receive,
        output data_received,
        output received,
        output receiving,
        output framing_error
    );

endinterface

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser for an asynchronous serial input plus a falling-edge
// detector on the synchronised value. All flops reset to the idle-high level.
module rx_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/rx_multi_byte.sv
// Serial receiver assembling 1..3 LSB-first bytes into a 24-bit word.
// Build option: define RX_TIMEOUT_EN to abandon partial frames after an idle gap.
module rx_multi_byte
    import uart_pkg::*;
#(
    parameter int SAMPLING_RATE = 16
`ifdef RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_BITS  = 4
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    rx_multi_byte_if.slave  bus
);

    localparam int CNT_W = $clog2(SAMPLING_RATE);
    localparam logic [CNT_W-1:0] CNT_MID     = CNT_W'(SAMPLING_RATE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END = CNT_W'(SAMPLING_RATE - 1);

`ifdef RX_TIMEOUT_EN
    localparam int TIMEOUT_CYC = TIMEOUT_BITS * SAMPLING_RATE;
    localparam int IDLE_W      = $clog2(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(TIMEOUT_CYC - 1);
    logic [IDLE_W-1:0] r_idle_cnt;
`endif

    logic w_line;
    logic w_fall;

    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [1:0]        r_byte_idx;
    logic [1:0]        r_len;
    logic [BYTE_W-1:0] r_shift;
    logic [DATA_W-1:0] r_assembly;
    logic [DATA_W-1:0] r_data_received;
    logic              r_received;
    logic              r_receiving;
    logic              r_framing_error;
    logic [DATA_W-1:0] w_word;

    rx_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.bit_in),
        .o_sync  (w_line),
        .o_fall  (w_fall)
    );

    // Assembly word with the byte just shifted in dropped into its lane.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
            assign w_word[DATA_W-1-BYTE_W*gi -: BYTE_W] =
                (r_byte_idx == 2'(gi)) ? r_shift
                                       : r_assembly[DATA_W-1-BYTE_W*gi -: BYTE_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_bit_idx       <= '0;
            r_byte_idx      <= '0;
            r_len           <= 2'd1;
            r_shift         <= '0;
            r_assembly      <= '0;
            r_data_received <= '0;
            r_received      <= 1'b0;
            r_receiving     <= 1'b0;
            r_framing_error <= 1'b0;
`ifdef RX_TIMEOUT_EN
            r_idle_cnt      <= '0;
`endif
        end else begin
            r_received      <= 1'b0;
            r_framing_error <= 1'b0;
`ifdef RX_TIMEOUT_EN
            r_idle_cnt      <= '0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= '0;
                        r_state <= START;
                        if (r_byte_idx == 2'd0) begin
                            r_receiving <= 1'b1;
                            r_shift     <= '0;
                            r_assembly  <= '0;
                            r_len       <= clamp_len(bus.bytes_to_receive);
                        end
                    end
`ifdef RX_TIMEOUT_EN
                    else if (r_byte_idx != 2'd0) begin
                        if (r_idle_cnt == IDLE_END) begin
                            r_framing_error <= 1'b1;
                            r_receiving     <= 1'b0;
                            r_byte_idx      <= '0;
                            r_assembly      <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
`endif
                end

                START: begin
                    if (r_cnt == CNT_MID) begin
                        if (!w_line) begin
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                            r_state   <= DATA;
                        end else begin
                            // Glitch: a partial frame survives, a fresh one is dropped.
                            r_state <= IDLE;
                            if (r_byte_idx == 2'd0) begin
                                r_receiving <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (r_cnt == CNT_BIT_END) begin
                        r_cnt   <= '0;
                        r_shift <= {w_line, r_shift[BYTE_W-1:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (r_cnt == CNT_BIT_END) begin
                        r_cnt <= '0;
                        if (w_line) begin
                            r_assembly <= w_word;
                            r_state    <= IDLE;
                            if ((r_byte_idx + 2'd1) == r_len) begin
                                r_data_received <= w_word;
                                r_received      <= 1'b1;
                                r_receiving     <= 1'b0;
                                r_byte_idx      <= '0;
                            end else begin
                                r_byte_idx <= r_byte_idx + 1'b1;
                            end
                        end else begin
                            r_framing_error <= 1'b1;
                            r_byte_idx      <= '0;
                            r_assembly      <= '0;
                            // An edge coinciding with the abort opens the next frame.
                            if (w_fall) begin
                                r_state     <= START;
                                r_receiving <= 1'b1;
                                r_shift     <= '0;
                                r_len       <= clamp_len(bus.bytes_to_receive);
                            end else begin
                                r_state     <= IDLE;
                                r_receiving <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_received = r_data_received;
    assign bus.received      = r_received;
    assign bus.receiving     = r_receiving;
    assign bus.framing_error = r_framing_error;

endmodule
